// File: rtl/raw10_pkg.sv
// raw10_pkg: RAW10 packing constants and the 5-byte group to 4-pixel unpack function
package raw10_pkg;

    localparam int PIX_W       = 10;
    localparam int PPC         = 4;
    localparam int GROUP_BYTES = 5;
    localparam int IN_BYTES    = 4;
    localparam int BUF_BYTES   = 12;

    // Byte b4 carries the two LSBs of every pixel, two bits per pixel starting at p0.
    function automatic logic [PPC*PIX_W-1:0] unpack_group(input logic [GROUP_BYTES*8-1:0] grp);
        logic [PPC*PIX_W-1:0] pix;
        for (int i = 0; i < PPC; i++)
            pix[i*PIX_W +: PIX_W] = {grp[i*8 +: 8], grp[PPC*8 + 2*i +: 2]};
        return pix;
    endfunction

endpackage

// File: rtl/raw10_unpacker.sv
// raw10_unpacker: 32-bit RAW10 byte stream to 40-bit 4-pixel stream gearbox with SOF/EOL framing
module raw10_unpacker
    import raw10_pkg::*;
(
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [IN_BYTES*8-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic [PPC*PIX_W-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     err_residual
);

    logic [BUF_BYTES*8-1:0] r_buf;
    logic [3:0]             r_cnt;
    logic                   r_sof_pending;
    logic                   r_eol_pending;
    logic                   r_err;
    logic [PPC*PIX_W-1:0]   r_tdata;
    logic                   r_tvalid;
    logic                   r_tuser;
    logic                   r_tlast;

    logic                   w_accept;
    logic                   w_out_free;
    logic                   w_pop;
    logic                   w_eol;
    logic                   w_final;
    logic                   w_short;
    logic [3:0]             w_cnt_in;
    logic [3:0]             w_base;
    logic [BUF_BYTES*8-1:0] w_shifted;
    logic [BUF_BYTES*8-1:0] w_buf_next;

    assign s_axis_tready = !areset && r_cnt <= 4'd8 && !r_eol_pending;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_out_free    = !r_tvalid || m_axis_tready;
    assign w_pop         = r_cnt >= 4'd5 && w_out_free;
    assign w_cnt_in      = r_cnt + (w_accept ? 4'd4 : 4'd0);
    // A tlast accepted on the same edge as a pop already counts toward ending the line,
    // so the final group of a line whose tail lands in that cycle still carries tlast.
    assign w_eol         = r_eol_pending || (w_accept && s_axis_tlast);
    assign w_final       = w_pop && w_eol && w_cnt_in < 4'd10;
    assign w_short       = r_eol_pending && r_cnt != 4'd0 && r_cnt < 4'd5;
    assign w_shifted     = w_pop ? r_buf >> (GROUP_BYTES*8) : r_buf;
    assign w_base        = w_pop ? r_cnt - 4'd5 : r_cnt;
    // Bytes above the append point may be stale after a line flush, so mask before merging.
    assign w_buf_next    = w_accept
                         ? (w_shifted & ~({(BUF_BYTES*8){1'b1}} << {w_base, 3'b000}))
                           | ({{((BUF_BYTES-IN_BYTES)*8){1'b0}}, s_axis_tdata} << {w_base, 3'b000})
                         : w_shifted;

    // Byte buffer, fill count and line framing flags.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_buf         <= '0;
            r_cnt         <= 4'd0;
            r_sof_pending <= 1'b0;
            r_eol_pending <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_buf         <= w_buf_next;
            r_cnt         <= (w_final || w_short) ? 4'd0 : w_cnt_in - (w_pop ? 4'd5 : 4'd0);
            r_eol_pending <= (w_final || w_short) ? 1'b0 : w_eol;
            r_sof_pending <= (w_accept && s_axis_tuser) || (r_sof_pending && !w_pop);
            r_err         <= r_err || w_short || (w_final && w_cnt_in != 4'd5);
        end
    end

    // Single output register stage; holds every field while the consumer stalls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_pop) begin
            r_tdata  <= unpack_group(r_buf[GROUP_BYTES*8-1:0]);
            r_tvalid <= 1'b1;
            r_tuser  <= r_sof_pending;
            r_tlast  <= w_final;
        end else if (w_out_free) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign err_residual  = r_err;

endmodule

// File: tb/tb_raw10_unpacker.sv
// tb_raw10_unpacker: randomized self-checking bench for the RAW10 unpacker against a byte-level model
module tb_raw10_unpacker;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [39:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        err_residual;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0]  line_b[$];
    logic [41:0] obs[$];
    logic [41:0] expq[$];
    logic        bp_mode = 1'b0;
    int          stall_viol = 0;
    int          stall_seen = 0;
    int          first_stalls = 0;
    int          rest_stalls = 0;
    logic        prev_stall = 1'b0;
    logic [42:0] prev_out = '0;

    raw10_unpacker dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .err_residual(err_residual)
    );

    always #5 aclk = ~aclk;

    // Output monitor: collect handshaken beats and watch stability across stalls.
    always @(negedge aclk) begin
        if (prev_stall && !areset) begin
            stall_seen <= stall_seen + 1;
            if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} !== prev_out)
                stall_viol <= stall_viol + 1;
        end
        prev_stall <= m_axis_tvalid && !m_axis_tready && !areset;
        prev_out   <= {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready)
            obs.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
    end

    // Consumer backpressure: ready alternates 1,0 every cycle when enabled.
    initial forever begin
        @(posedge aclk);
        #1;
        if (bp_mode) m_axis_tready = ~m_axis_tready;
    end

    task automatic rand_line(input int nbytes);
        line_b = {};
        repeat (nbytes) line_b.push_back(8'($urandom));
    endtask

    // Reference: every complete 5-byte group of the line becomes one beat; leftovers vanish.
    task automatic build_expect(input bit sof);
        int ng;
        int b4;
        logic [39:0] d;
        ng = line_b.size() / 5;
        expq = {};
        for (int g = 0; g < ng; g++) begin
            d = '0;
            b4 = int'(line_b[5*g+4]);
            for (int i = 0; i < 4; i++)
                d = d | (40'(int'(line_b[5*g+i]) * 4 + ((b4 >> (2*i)) & 3)) << (10*i));
            expq.push_back({d, sof && g == 0, g == ng - 1});
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input int maxgap, output int stalls);
        int t;
        t = 0;
        stalls = 0;
        repeat ($urandom_range(maxgap, 0)) begin
            @(posedge aclk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && t < 200) begin
            stalls++;
            t++;
            @(negedge aclk);
        end
        if (!s_axis_tready) begin
            n_tests++;
            n_fail++;
            $display("FAIL input_accept_timeout: s_axis_tready=%b after %0d cycles, want 1", s_axis_tready, t);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_line(input bit sof, input int maxgap, input int nbeats);
        int st;
        first_stalls = 0;
        rest_stalls = 0;
        for (int k = 0; k < nbeats; k++) begin
            send_beat({line_b[4*k+3], line_b[4*k+2], line_b[4*k+1], line_b[4*k]},
                      sof && k == 0, k == line_b.size() / 4 - 1, maxgap, st);
            if (k == 0) first_stalls = st;
            else rest_stalls += st;
        end
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (obs.size() < expq.size() && t < 20000) begin
            @(posedge aclk);
            t++;
        end
        repeat (8) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        #2 areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
        obs = {};
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast});
        end
        n_tests++;
        if (s_axis_tready !== 1'b0 || err_residual !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_err: tready=%b err=%b, want 0 0", s_axis_tready, err_residual);
        end
        @(posedge aclk);
        #1 areset = 1'b0;
        #1;
        n_tests++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b, want 1", s_axis_tready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_single_group();
        int shown;
        line_b = {8'h01, 8'h02, 8'h03, 8'h04, 8'hE4};
        repeat (15) line_b.push_back(8'h00);
        build_expect(1'b1);
        obs = {};
        send_line(1'b1, 0, 5);
        wait_out();
        n_tests++;
        if (obs.size() != 4) begin
            n_fail++;
            $display("FAIL single_count: got %0d beats, want 4", obs.size());
        end
        n_tests++;
        if (obs.size() == 0 || obs[0] !== {10'h013, 10'h00E, 10'h009, 10'h004, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_beat0: got %h, want %h", obs.size() ? obs[0] : 42'd0,
                     {10'h013, 10'h00E, 10'h009, 10'h004, 1'b1, 1'b0});
        end
        shown = 0;
        for (int i = 0; i < expq.size(); i++) begin
            n_tests++;
            if (i >= obs.size() || obs[i] !== expq[i]) begin
                n_fail++;
                if (shown++ < 5) $display("FAIL single_beat %0d: got %h, want %h", i, i < obs.size() ? obs[i] : 42'd0, expq[i]);
            end
        end
        n_tests++;
        if (err_residual !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err: got %b, want 0", err_residual);
        end
    endtask

    task automatic test_full_frame();
        int shown;
        for (int l = 0; l < 4; l++) begin
            rand_line(10240);
            build_expect(l == 0);
            obs = {};
            send_line(l == 0, 0, 2560);
            wait_out();
            n_tests++;
            if (obs.size() != 2048) begin
                n_fail++;
                $display("FAIL frame_count line %0d: got %0d beats, want 2048", l, obs.size());
            end
            shown = 0;
            for (int i = 0; i < expq.size(); i++) begin
                n_tests++;
                if (i >= obs.size() || obs[i] !== expq[i]) begin
                    n_fail++;
                    if (shown++ < 5) $display("FAIL frame_beat line %0d beat %0d: got %h, want %h", l, i, i < obs.size() ? obs[i] : 42'd0, expq[i]);
                end
            end
            n_tests++;
            if (rest_stalls != 0) begin
                n_fail++;
                $display("FAIL frame_ready line %0d: got %0d stalled cycles, want 0", l, rest_stalls);
            end
            if (l > 0) begin
                n_tests++;
                if (first_stalls > 2) begin
                    n_fail++;
                    $display("FAIL line_gap line %0d: got %0d cycles, want <= 2", l, first_stalls);
                end
            end
        end
        n_tests++;
        if (err_residual !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err: got %b, want 0", err_residual);
        end
    endtask

    task automatic test_backpressure();
        int shown;
        stall_viol = 0;
        stall_seen = 0;
        bp_mode = 1'b1;
        for (int l = 0; l < 3; l++) begin
            rand_line(20 * $urandom_range(10, 2));
            build_expect(l == 0);
            obs = {};
            send_line(l == 0, 2, line_b.size() / 4);
            wait_out();
            shown = 0;
            n_tests++;
            if (obs.size() != expq.size()) begin
                n_fail++;
                $display("FAIL bp_count line %0d: got %0d beats, want %0d", l, obs.size(), expq.size());
            end
            for (int i = 0; i < expq.size(); i++) begin
                n_tests++;
                if (i >= obs.size() || obs[i] !== expq[i]) begin
                    n_fail++;
                    if (shown++ < 5) $display("FAIL bp_beat line %0d beat %0d: got %h, want %h", l, i, i < obs.size() ? obs[i] : 42'd0, expq[i]);
                end
            end
        end
        bp_mode = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        n_tests++;
        if (stall_viol != 0 || stall_seen == 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d changes over %0d stalls, want 0 changes over >0 stalls", stall_viol, stall_seen);
        end
    endtask

    task automatic test_residual();
        int shown;
        do_reset();
        rand_line(24);
        build_expect(1'b0);
        send_line(1'b0, 0, 6);
        wait_out();
        n_tests++;
        if (obs.size() != 4 || (obs.size() == 4 && obs[3][0] !== 1'b1)) begin
            n_fail++;
            $display("FAIL residual_count: got %0d beats, want 4 with tlast on the 4th", obs.size());
        end
        shown = 0;
        for (int i = 0; i < expq.size(); i++) begin
            n_tests++;
            if (i >= obs.size() || obs[i] !== expq[i]) begin
                n_fail++;
                if (shown++ < 5) $display("FAIL residual_beat %0d: got %h, want %h", i, i < obs.size() ? obs[i] : 42'd0, expq[i]);
            end
        end
        n_tests++;
        if (err_residual !== 1'b1) begin
            n_fail++;
            $display("FAIL residual_err: got %b, want 1", err_residual);
        end
        rand_line(20);
        build_expect(1'b0);
        obs = {};
        send_line(1'b0, 0, 5);
        wait_out();
        n_tests++;
        if (err_residual !== 1'b1 || obs.size() != 4) begin
            n_fail++;
            $display("FAIL residual_sticky: err=%b beats=%0d, want 1 4", err_residual, obs.size());
        end
        do_reset();
        n_tests++;
        if (err_residual !== 1'b0) begin
            n_fail++;
            $display("FAIL residual_clear: got %b, want 0", err_residual);
        end
    endtask

    task automatic test_short_line();
        int shown;
        do_reset();
        rand_line(4);
        expq = {};
        send_line(1'b0, 0, 1);
        wait_out();
        n_tests++;
        if (obs.size() != 0 || err_residual !== 1'b1) begin
            n_fail++;
            $display("FAIL short_line: beats=%0d err=%b, want 0 1", obs.size(), err_residual);
        end
        rand_line(20);
        build_expect(1'b1);
        obs = {};
        send_line(1'b1, 0, 5);
        wait_out();
        shown = 0;
        n_tests++;
        if (obs.size() != 4) begin
            n_fail++;
            $display("FAIL short_next_count: got %0d beats, want 4", obs.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            n_tests++;
            if (i >= obs.size() || obs[i] !== expq[i]) begin
                n_fail++;
                if (shown++ < 5) $display("FAIL short_next_beat %0d: got %h, want %h", i, i < obs.size() ? obs[i] : 42'd0, expq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int shown;
        do_reset();
        rand_line(10240);
        send_line(1'b1, 0, 700);
        #2 areset = 1'b1;
        #1;
        n_tests++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, s_axis_tready} !== 44'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, want 0", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, s_axis_tready});
        end
        @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
        rand_line(20);
        build_expect(1'b1);
        obs = {};
        send_line(1'b1, 0, 5);
        wait_out();
        shown = 0;
        n_tests++;
        if (obs.size() != 4) begin
            n_fail++;
            $display("FAIL after_reset_count: got %0d beats, want 4", obs.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            n_tests++;
            if (i >= obs.size() || obs[i] !== expq[i]) begin
                n_fail++;
                if (shown++ < 5) $display("FAIL after_reset_beat %0d: got %h, want %h", i, i < obs.size() ? obs[i] : 42'd0, expq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_full_frame();
        test_backpressure();
        test_residual();
        test_short_line();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
